// File: rtl/ffstdp_weight_sweeper_if.sv
// Bundle of every non-clock/reset signal of the FF-STDP weight sweeper:
// controller handshake, spike-count memories, synapse SRAM and update unit.
interface ffstdp_weight_sweeper_if #(
    parameter int N_PRE          = 256,
    parameter int N_POST         = 256,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int PRE_CNT_WIDTH  = 8,
    parameter int POST_CNT_WIDTH = 7
);
    localparam int PRE_AW  = $clog2(N_PRE);
    localparam int POST_AW = $clog2(N_POST);
    localparam int SYN_AW  = PRE_AW + POST_AW;

    // controller
    logic                      start;
    logic                      is_pos;
    logic                      is_train;
    logic                      busy;
    logic                      done;
    // spike-count memories
    logic [PRE_AW-1:0]         pre_cnt_addr;
    logic [PRE_CNT_WIDTH-1:0]  pre_cnt_rdata;
    logic [POST_AW-1:0]        post_cnt_addr;
    logic [POST_CNT_WIDTH-1:0] post_cnt_rdata;
    // synapse SRAM
    logic                      syn_cs;
    logic                      syn_we;
    logic [SYN_AW-1:0]         syn_addr;
    logic [WEIGHT_WIDTH-1:0]   syn_wdata;
    logic [WEIGHT_WIDTH-1:0]   syn_rdata;
    // update unit
    logic                      upd_tref_event;
    logic                      upd_is_pos;
    logic [PRE_CNT_WIDTH-1:0]  upd_pre_cnt;
    logic [POST_CNT_WIDTH-1:0] upd_post_cnt;
    logic [WEIGHT_WIDTH-1:0]   upd_wsyn_curr;
    logic [WEIGHT_WIDTH-1:0]   upd_wsyn_new;

    modport master (
        input  start, is_pos, is_train,
        input  pre_cnt_rdata, post_cnt_rdata, syn_rdata, upd_wsyn_new,
        output busy, done,
        output pre_cnt_addr, post_cnt_addr,
        output syn_cs, syn_we, syn_addr, syn_wdata,
        output upd_tref_event, upd_is_pos, upd_pre_cnt, upd_post_cnt, upd_wsyn_curr
    );

    modport slave (
        output start, is_pos, is_train,
        output pre_cnt_rdata, post_cnt_rdata, syn_rdata, upd_wsyn_new,
        input  busy, done,
        input  pre_cnt_addr, post_cnt_addr,
        input  syn_cs, syn_we, syn_addr, syn_wdata,
        input  upd_tref_event, upd_is_pos, upd_pre_cnt, upd_post_cnt, upd_wsyn_curr
    );
endinterface

// File: rtl/ffstdp_weight_sweeper.sv
// Post-sample weight sweeper: visits every synapse in {post, pre} order, reads
// weight and spike counts, and writes back the update unit's new weight.
module ffstdp_weight_sweeper #(
    parameter int N_PRE          = 256,
    parameter int N_POST         = 256,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int PRE_CNT_WIDTH  = 8,
    parameter int POST_CNT_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ffstdp_weight_sweeper_if.master     bus
);
    localparam int PRE_AW  = $clog2(N_PRE);
    localparam int POST_AW = $clog2(N_POST);

    localparam logic [PRE_AW-1:0]  PRE_LAST  = PRE_AW'(N_PRE - 1);
    localparam logic [POST_AW-1:0] POST_LAST = POST_AW'(N_POST - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WB   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t              state_reg,    state_next;
    logic [PRE_AW-1:0]   pre_idx_reg,  pre_idx_next;
    logic [POST_AW-1:0]  post_idx_reg, post_idx_next;
    logic                is_pos_reg,   is_pos_next;

    logic                pre_cnt_nonzero;
    logic                last_synapse;

    assign pre_cnt_nonzero = (bus.pre_cnt_rdata != PRE_CNT_WIDTH'(0));
    assign last_synapse    = (pre_idx_reg == PRE_LAST) && (post_idx_reg == POST_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            pre_idx_reg  <= '0;
            post_idx_reg <= '0;
            is_pos_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pre_idx_reg  <= pre_idx_next;
            post_idx_reg <= post_idx_next;
            is_pos_reg   <= is_pos_next;
        end
    end

    // Count memories and update unit are consumed in the WB cycle, so the
    // read data is handed straight through without an extra register stage.
    assign bus.upd_pre_cnt   = bus.pre_cnt_rdata;
    assign bus.upd_post_cnt  = bus.post_cnt_rdata;
    assign bus.upd_wsyn_curr = bus.syn_rdata;
    assign bus.upd_is_pos    = is_pos_reg;

    // Indices hold steady across RD and WB, so addresses need no state decode.
    assign bus.pre_cnt_addr  = pre_idx_reg;
    assign bus.post_cnt_addr = post_idx_reg;
    assign bus.syn_addr      = {post_idx_reg, pre_idx_reg};

    always_comb begin
        state_next         = state_reg;
        pre_idx_next       = pre_idx_reg;
        post_idx_next      = post_idx_reg;
        is_pos_next        = is_pos_reg;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.syn_cs         = 1'b0;
        bus.syn_we         = 1'b0;
        bus.syn_wdata      = WEIGHT_WIDTH'(0);
        bus.upd_tref_event = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.is_train) begin
                        is_pos_next = bus.is_pos;
                        state_next  = ST_RD;
                    end else begin
                        state_next  = ST_FIN;
                    end
                end
            end

            ST_RD: begin
                bus.busy   = 1'b1;
                bus.syn_cs = 1'b1;
                state_next = ST_WB;
            end

            ST_WB: begin
                bus.busy           = 1'b1;
                bus.upd_tref_event = 1'b1;
                // A synapse whose presynaptic neuron never fired keeps its weight.
                if (pre_cnt_nonzero) begin
                    bus.syn_cs    = 1'b1;
                    bus.syn_we    = 1'b1;
                    bus.syn_wdata = bus.upd_wsyn_new;
                end
                pre_idx_next = pre_idx_reg + PRE_AW'(1);
                if (pre_idx_reg == PRE_LAST) begin
                    post_idx_next = post_idx_reg + POST_AW'(1);
                end
                state_next = last_synapse ? ST_FIN : ST_RD;
            end

            ST_FIN: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end
endmodule
